// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed seven-segment scanner.
//   - SEG_A..SEG_G : bit positions of each segment in the 7-bit pattern
//   - HEX_SEG      : active-high hex-to-segment table, index = nibble value
//   - lz_mask()    : leading-zero suppression mask for up to MAX_DIG digits
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int MAX_DIG = 8;

    // One-hot masks per segment so the table below reads as segment lists.
    localparam logic [6:0] SA = 7'(1 << SEG_A);
    localparam logic [6:0] SB = 7'(1 << SEG_B);
    localparam logic [6:0] SC = 7'(1 << SEG_C);
    localparam logic [6:0] SD = 7'(1 << SEG_D);
    localparam logic [6:0] SE = 7'(1 << SEG_E);
    localparam logic [6:0] SF = 7'(1 << SEG_F);
    localparam logic [6:0] SG = 7'(1 << SEG_G);

    localparam logic [6:0] HEX_SEG [16] = '{
        SA | SB | SC | SD | SE | SF,        // 0
        SB | SC,                            // 1
        SA | SB | SD | SE | SG,             // 2
        SA | SB | SC | SD | SG,             // 3
        SB | SC | SF | SG,                  // 4
        SA | SC | SD | SF | SG,             // 5
        SA | SC | SD | SE | SF | SG,        // 6
        SA | SB | SC,                       // 7
        SA | SB | SC | SD | SE | SF | SG,   // 8
        SA | SB | SC | SD | SF | SG,        // 9
        SA | SB | SC | SE | SF | SG,        // A
        SC | SD | SE | SF | SG,             // b
        SA | SD | SE | SF,                  // C
        SB | SC | SD | SE | SG,             // d
        SA | SD | SE | SF | SG,             // E
        SA | SE | SF | SG                   // F
    };

    // Bit k set means digit k is a leading zero to be suppressed. Scans from
    // the most significant populated digit downwards; digit 0 always stays.
    function automatic logic [MAX_DIG-1:0] lz_mask(input logic [4*MAX_DIG-1:0] digits,
                                                  input int n_dig);
        logic leading;
        lz_mask = '0;
        leading = 1'b1;
        for (int i = MAX_DIG - 1; i >= 1; i--) begin
            if (i < n_dig) begin
                if (leading && (digits[4*i +: 4] == 4'd0)) begin
                    lz_mask[i] = 1'b1;
                end else begin
                    leading = 1'b0;
                end
            end
        end
    endfunction

endpackage

// File: rtl/seg7_scan_n_if.sv
// seg7_scan_n_if: bundle between the digit source and the scanner.
//   digits/dots/blank/lz_en/bright/load : display content + capture strobe
//   segment/dot/dig_en                  : pin-level drive (after polarity)
//   upd_pend/frame_done                 : status back to the digit source
// master = digit source, slave = scanner.
interface seg7_scan_n_if #(
    parameter int N_DIG    = 4,
    parameter int BRIGHT_W = 3
);
    logic [4*N_DIG-1:0]  digits;
    logic [N_DIG-1:0]    dots;
    logic [N_DIG-1:0]    blank;
    logic                lz_en;
    logic [BRIGHT_W-1:0] bright;
    logic                load;
    logic [6:0]          segment;
    logic                dot;
    logic [N_DIG-1:0]    dig_en;
    logic                upd_pend;
    logic                frame_done;

    modport master (
        output digits, dots, blank, lz_en, bright, load,
        input  segment, dot, dig_en, upd_pend, frame_done
    );

    modport slave (
        input  digits, dots, blank, lz_en, bright, load,
        output segment, dot, dig_en, upd_pend, frame_done
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble -> active-high segment pattern.
//   nibble : hex value 0..F
//   seg    : bit SEG_A..SEG_G, 1 = segment lit
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan_n.sv
// seg7_scan_n: N-digit multiplexed seven-segment scanner.
//   FPGA_CLK : system clock
//   RESET    : synchronous active-high reset
//   bus      : seg7_scan_n_if.slave (content in, segment/dot/dig_en and status out)
// Inputs are captured into staging on load and promoted to the active set at
// the start of the digit-0 slot, so a frame never shows a mix of two updates.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int SLOT_HZ     = 1000,
    parameter int GAP         = 16,
    parameter int BRIGHT_W    = 3,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic         FPGA_CLK,
    input  logic         RESET,
    seg7_scan_n_if.slave bus
);
    localparam int SLOT  = CLK_HZ / SLOT_HZ;
    localparam int CNT_W = $clog2(SLOT);
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);
    localparam logic             SEG_INV   = (SEG_ACT_LOW != 0);
    localparam logic             DIG_INV   = (DIG_ACT_LOW != 0);

    logic [CNT_W-1:0]    slot_cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                upd_pend_reg;

    logic [4*N_DIG-1:0]  stg_digits_reg, act_digits_reg;
    logic [N_DIG-1:0]    stg_dots_reg,   act_dots_reg;
    logic [N_DIG-1:0]    stg_blank_reg,  act_blank_reg;
    logic                stg_lz_reg,     act_lz_reg;
    logic [BRIGHT_W-1:0] stg_bright_reg, act_bright_reg;

    logic [6:0]          segment_reg;
    logic                dot_reg;
    logic [N_DIG-1:0]    dig_en_reg;
    logic                frame_done_reg;

    logic                slot_last, idx_last, commit;
    logic [4*N_DIG-1:0]  cur_digits;
    logic [N_DIG-1:0]    cur_dots, cur_blank;
    logic                cur_lz;
    logic [BRIGHT_W-1:0] cur_bright;
    logic [3:0]          nib_arr [N_DIG];
    logic [MAX_DIG-1:0]  lz_full;
    logic [6:0]          dec_pat, pattern;
    logic [BRIGHT_W-1:0] pwm;
    logic                window, dark, cur_dot, drive;
    logic [N_DIG-1:0]    dig_onehot;

    assign slot_last = (slot_cnt_reg == SLOT_LAST);
    assign idx_last  = (idx_reg == IDX_LAST);
    assign commit    = upd_pend_reg && (idx_reg == '0) && (slot_cnt_reg == '0);

    // On the commit cycle the output registers already see the staged set, so
    // the first cycle of the new frame shows the new content.
    assign cur_digits = commit ? stg_digits_reg : act_digits_reg;
    assign cur_dots   = commit ? stg_dots_reg   : act_dots_reg;
    assign cur_blank  = commit ? stg_blank_reg  : act_blank_reg;
    assign cur_lz     = commit ? stg_lz_reg     : act_lz_reg;
    assign cur_bright = commit ? stg_bright_reg : act_bright_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_nib
            assign nib_arr[gi] = cur_digits[4*gi +: 4];
        end
    endgenerate

    assign lz_full = lz_mask(32'(cur_digits), N_DIG);

    seg7_hex_decode u_dec (
        .nibble (nib_arr[idx_reg]),
        .seg    (dec_pat)
    );

    // pwm < bright+1 is written as pwm <= bright to keep it in BRIGHT_W bits.
    assign pwm     = BRIGHT_W'(slot_cnt_reg - GAP_C);
    assign window  = (slot_cnt_reg >= GAP_C) && ((cur_bright == '1) || (pwm <= cur_bright));
    assign dark    = cur_blank[idx_reg] | (cur_lz & lz_full[3'(idx_reg)]);
    assign cur_dot = cur_dots[idx_reg];
    assign pattern = dark ? 7'd0 : dec_pat;
    // A dark digit is still enabled when its dot must light.
    assign drive      = window && (!dark || cur_dot);
    assign dig_onehot = drive ? (N_DIG'(1) << idx_reg) : '0;

    always_ff @(posedge FPGA_CLK) begin
        if (RESET) begin
            slot_cnt_reg   <= '0;
            idx_reg        <= '0;
            upd_pend_reg   <= 1'b0;
            stg_digits_reg <= '0;
            stg_dots_reg   <= '0;
            stg_blank_reg  <= '1;
            stg_lz_reg     <= 1'b0;
            stg_bright_reg <= '1;
            act_digits_reg <= '0;
            act_dots_reg   <= '0;
            act_blank_reg  <= '1;
            act_lz_reg     <= 1'b0;
            act_bright_reg <= '1;
            segment_reg    <= {7{SEG_INV}};
            dot_reg        <= SEG_INV;
            dig_en_reg     <= {N_DIG{DIG_INV}};
            frame_done_reg <= 1'b0;
        end else begin
            if (slot_last) begin
                slot_cnt_reg <= '0;
                idx_reg      <= idx_last ? '0 : idx_reg + IDX_W'(1);
            end else begin
                slot_cnt_reg <= slot_cnt_reg + CNT_W'(1);
            end

            if (bus.load) begin
                stg_digits_reg <= bus.digits;
                stg_dots_reg   <= bus.dots;
                stg_blank_reg  <= bus.blank;
                stg_lz_reg     <= bus.lz_en;
                stg_bright_reg <= bus.bright;
            end

            if (commit) begin
                act_digits_reg <= stg_digits_reg;
                act_dots_reg   <= stg_dots_reg;
                act_blank_reg  <= stg_blank_reg;
                act_lz_reg     <= stg_lz_reg;
                act_bright_reg <= stg_bright_reg;
            end

            // A load on the commit cycle keeps the flag set for the next frame.
            upd_pend_reg <= bus.load | (upd_pend_reg & ~commit);

            segment_reg    <= pattern ^ {7{SEG_INV}};
            dot_reg        <= cur_dot ^ SEG_INV;
            dig_en_reg     <= dig_onehot ^ {N_DIG{DIG_INV}};
            frame_done_reg <= slot_last && idx_last;
        end
    end

    assign bus.segment    = segment_reg;
    assign bus.dot        = dot_reg;
    assign bus.dig_en     = dig_en_reg;
    assign bus.upd_pend   = upd_pend_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_n.sv
// tb_seg7_scan_n: scoreboard bench for seg7_scan_n (N_DIG=4, SLOT=16, GAP=4).
// Stimulus loads display content mid-frame and queues the content expected in
// the following frame; a negedge monitor compares every output cycle of every
// frame against a reference model of what the display should show.
module tb_seg7_scan_n;
    localparam int N_DIG = 4;
    localparam int SLOT  = 16;
    localparam int GAP   = 4;
    localparam int FRAME = N_DIG * SLOT;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dots;
        logic [3:0]  blank;
        logic        lz;
        logic [2:0]  bright;
    } cfg_t;

    typedef struct {
        cfg_t cfg;
        int   frame;
    } exp_t;

    localparam cfg_t RESET_CFG = '{digits: 16'h0000, dots: 4'h0, blank: 4'hF, lz: 1'b0, bright: 3'h7};

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    seg7_scan_n_if #(.N_DIG(N_DIG), .BRIGHT_W(3)) bus ();

    seg7_scan_n #(
        .N_DIG(N_DIG), .CLK_HZ(160), .SLOT_HZ(10), .GAP(GAP),
        .BRIGHT_W(3), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .FPGA_CLK (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected {segment, dot, dig_en} (pin levels, active-low) at frame cycle pos.
    function automatic logic [11:0] model(input cfg_t c, input int pos);
        int          k = pos / SLOT;
        int          p = pos % SLOT;
        logic [15:0] upper;
        logic [6:0]  seg_on;
        logic [3:0]  one = 4'b0001;
        logic [3:0]  en_bits;
        bit          dark, lit, en;
        upper   = c.digits >> (4 * k);            // digits k..3
        dark    = c.blank[k] || (c.lz && k != 0 && upper == 16'h0);
        lit     = (p >= GAP) && (c.bright == 3'd7 || ((p - GAP) % 8) <= int'(c.bright));
        en      = lit && (!dark || c.dots[k]);
        seg_on  = dark ? 7'h00 : HEX[upper[3:0]];
        en_bits = en ? ~(one << k) : 4'hF;
        return {~seg_on, ~c.dots[k], en_bits};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t        exp_q[$];
    exp_t        e;
    cfg_t        mon_cfg = RESET_CFG;
    bit          mon_en  = 1'b0;
    bit          seen_fd = 1'b0;
    int          pos = 0;
    int          frame_cnt = 0;
    logic [11:0] got_v, want_v;

    always @(negedge clk) begin
        if (mon_en) begin
            if (seen_fd) begin
                if (pos < FRAME) begin
                    want_v = model(mon_cfg, pos);
                    got_v  = {bus.segment, bus.dot, bus.dig_en};
                    n_tests++;
                    if (got_v !== want_v) begin
                        n_fail++;
                        $display("FAIL scan frame=%0d pos=%0d: got seg=%h dot=%b en=%b, expected seg=%h dot=%b en=%b",
                                 frame_cnt, pos, got_v[11:5], got_v[4], got_v[3:0],
                                 want_v[11:5], want_v[4], want_v[3:0]);
                    end
                    if (pos == 0) check("upd_pend_at_frame_start", 32'(bus.upd_pend), 32'd0);
                end
                if (pos == FRAME - 1) check("frame_done_at_frame_end", 32'(bus.frame_done), 32'd1);
                else if (bus.frame_done) check("frame_done_period_pos", pos, FRAME - 1);
            end
            if (bus.frame_done) begin
                seen_fd = 1'b1;
                pos = 0;
                frame_cnt++;
                if (exp_q.size() > 0 && exp_q[0].frame == frame_cnt) begin
                    e = exp_q.pop_front();
                    mon_cfg = e.cfg;
                end
            end else if (seen_fd) begin
                pos++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_fd();
        bit ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_done_seen", 32'(ok), 32'd1);
    endtask

    task automatic drive_load(input cfg_t c);
        bus.digits = c.digits;
        bus.dots   = c.dots;
        bus.blank  = c.blank;
        bus.lz_en  = c.lz;
        bus.bright = c.bright;
        bus.load   = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        @(negedge clk);
        check("upd_pend_after_load", 32'(bus.upd_pend), 32'd1);
    endtask

    task automatic send(input cfg_t c, input bit dbl, input cfg_t first, input int txn);
        int   d;
        int   target;
        exp_t ex;
        wait_fd();
        @(posedge clk);
        #1;
        target = frame_cnt + 1;
        d = $urandom_range(0, 40);
        repeat (d) @(posedge clk);
        #1;
        if (dbl) begin
            drive_load(first);
            @(posedge clk);
            #1;
        end
        drive_load(c);
        ex.cfg = c;
        ex.frame = target;
        exp_q.push_back(ex);
        $display("[TB] txn %0d: digits=%h dots=%b blank=%b lz=%0d bright=%0d double=%0d -> frame %0d",
                 txn, c.digits, c.dots, c.blank, c.lz, c.bright, dbl, target);
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t        c;
        logic [15:0] all_ones = 16'hFFFF;
        logic [15:0] m;
        m         = all_ones >> (4 * $urandom_range(0, 4));
        c.digits  = 16'($urandom) & m;
        c.dots    = 4'($urandom) & 4'($urandom);
        c.blank   = 4'($urandom) & 4'($urandom) & 4'($urandom);
        c.lz      = 1'($urandom);
        c.bright  = 3'($urandom);
        return c;
    endfunction

    initial begin
        cfg_t c, c1;
        int   n;
        bit   ok;
        bus.digits = '0;
        bus.dots   = '0;
        bus.blank  = '0;
        bus.lz_en  = 1'b0;
        bus.bright = '0;
        bus.load   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_segment", 32'(bus.segment), 32'h7F);
        check("reset_dot", 32'(bus.dot), 32'd1);
        check("reset_dig_en", 32'(bus.dig_en), 32'hF);
        check("reset_upd_pend", 32'(bus.upd_pend), 32'd0);
        check("reset_frame_done", 32'(bus.frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Two idle frames shown with reset content.
        wait_fd();
        wait_fd();

        c = '{digits: 16'h1234, dots: 4'h0, blank: 4'h0, lz: 1'b0, bright: 3'd7};
        send(c, 1'b0, c, 0);
        c = '{digits: 16'h0070, dots: 4'b1000, blank: 4'h0, lz: 1'b1, bright: 3'd7};
        send(c, 1'b0, c, 1);
        c = '{digits: 16'h1234, dots: 4'h0, blank: 4'h0, lz: 1'b0, bright: 3'd0};
        send(c, 1'b0, c, 2);
        c1 = '{digits: 16'h1111, dots: 4'h0, blank: 4'h0, lz: 1'b0, bright: 3'd7};
        c  = '{digits: 16'h2222, dots: 4'h0, blank: 4'h0, lz: 1'b0, bright: 3'd7};
        send(c, 1'b1, c1, 3);
        for (int t = 4; t < 14; t++) begin
            send(rand_cfg(), 1'b0, c, t);
        end
        wait_fd();
        wait_fd();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        // Reset in the middle of the digit-2 slot with an update pending.
        wait_fd();
        @(posedge clk);
        #1;
        repeat (2 * SLOT + 5) @(posedge clk);
        #1;
        mon_en = 1'b0;
        c = '{digits: 16'h5678, dots: 4'hF, blank: 4'h0, lz: 1'b0, bright: 3'd7};
        bus.digits = c.digits;
        bus.dots   = c.dots;
        bus.blank  = c.blank;
        bus.lz_en  = c.lz;
        bus.bright = c.bright;
        bus.load   = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_segment", 32'(bus.segment), 32'h7F);
        check("rst_mid_dot", 32'(bus.dot), 32'd1);
        check("rst_mid_dig_en", 32'(bus.dig_en), 32'hF);
        check("rst_mid_upd_pend", 32'(bus.upd_pend), 32'd0);
        check("rst_mid_frame_done", 32'(bus.frame_done), 32'd0);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            n++;
            if (bus.frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_frame_done_delay", n, FRAME);
        if (ok) begin
            for (int p = 0; p < FRAME; p++) begin
                @(negedge clk);
                check("post_reset_scan", 32'({bus.segment, bus.dot, bus.dig_en}), 32'(model(RESET_CFG, p)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
